ram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 2 KB single-port on-chip RAM (11-bit address, 8-bit data, synchronous read and write). The RAM is shared between the CPU core (requester A) and a loader/debug DMA port (requester B). The block serialises their accesses through one fixed four-state sequence, registers every RAM control signal, and returns captured read data with a one-cycle acknowledge pulse. It sits between the two requesters and the RAM instance and is the only driver of the RAM's address, data_in and write_enable.

---
 rtl/ram_arbiter_if.sv | 45 ++++
 rtl/ram_arbiter.sv | 103 ++++++++++
 tb/tb_ram_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester and RAM-side signal bundle for ram_arbiter
//
// Purpose: groups both requester handshakes and the RAM port into one bundle.
// Ports (signals):
//   req_a/req_b, we_a/we_b, addr_a/addr_b, wdata_a/wdata_b : requester inputs
//   ack_a/ack_b, rdata_a/rdata_b, busy                     : arbiter responses
//   mem_address, mem_data_in, mem_write_enable             : arbiter -> RAM
//   mem_data_out                                           : RAM -> arbiter
// Modports: slave = arbiter side, master = requester/RAM side.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) ();
  logic                  req_a;
  logic                  req_b;
  logic                  we_a;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] wdata_a;
  logic [DATA_WIDTH-1:0] wdata_b;
  logic                  ack_a;
  logic                  ack_b;
  logic [DATA_WIDTH-1:0] rdata_a;
  logic [DATA_WIDTH-1:0] rdata_b;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_write_enable;
  logic [DATA_WIDTH-1:0] mem_data_out;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    input  mem_data_out,
    output ack_a, ack_b, rdata_a, rdata_b, busy,
    output mem_address, mem_data_in, mem_write_enable
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    output mem_data_out,
    input  ack_a, ack_b, rdata_a, rdata_b, busy,
    input  mem_address, mem_data_in, mem_write_enable
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester arbiter/sequencer for a single-port RAM
//
// Purpose: serialises accesses from requester A and B onto one synchronous
// single-port RAM through a fixed IDLE -> ACCESS -> WAIT -> ACK sequence,
// alternating on ties, with all outputs registered.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : ram_arbiter_if.slave (requester handshakes + RAM port)
module ram_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  state_t state;
  logic   owner_b;       // 1 = current transaction belongs to B
  logic   last_grant_b;  // 1 = B was granted most recently
  logic   op_write;      // current transaction is a write
  logic   grant_a;
  logic   grant_b;

  // A wins when alone or when B held the previous grant.
  always_comb begin
    grant_a = bus.req_a && (!bus.req_b || last_grant_b);
    grant_b = bus.req_b && !grant_a;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= ST_IDLE;
      owner_b              <= 1'b0;
      last_grant_b         <= 1'b1;
      op_write             <= 1'b0;
      bus.ack_a            <= 1'b0;
      bus.ack_b            <= 1'b0;
      bus.rdata_a          <= '0;
      bus.rdata_b          <= '0;
      bus.busy             <= 1'b0;
      bus.mem_address      <= '0;
      bus.mem_data_in      <= '0;
      bus.mem_write_enable <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_a) begin
            bus.mem_address      <= bus.addr_a;
            bus.mem_data_in      <= bus.wdata_a;
            bus.mem_write_enable <= bus.we_a;
            op_write             <= bus.we_a;
            owner_b              <= 1'b0;
            last_grant_b         <= 1'b0;
            bus.busy             <= 1'b1;
            state                <= ST_ACCESS;
          end else if (grant_b) begin
            bus.mem_address      <= bus.addr_b;
            bus.mem_data_in      <= bus.wdata_b;
            bus.mem_write_enable <= bus.we_b;
            op_write             <= bus.we_b;
            owner_b              <= 1'b1;
            last_grant_b         <= 1'b1;
            bus.busy             <= 1'b1;
            state                <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // The RAM commits the access at this edge; drop the strobe now.
          bus.mem_write_enable <= 1'b0;
          state                <= ST_WAIT;
        end
        ST_WAIT: begin
          // mem_data_out reflects the address presented during ACCESS.
          if (owner_b) begin
            if (!op_write) bus.rdata_b <= bus.mem_data_out;
            bus.ack_b <= 1'b1;
          end else begin
            if (!op_write) bus.rdata_a <= bus.mem_data_out;
            bus.ack_a <= 1'b1;
          end
          state <= ST_ACK;
        end
        ST_ACK: begin
          bus.ack_a <= 1'b0;
          bus.ack_b <= 1'b0;
          bus.busy  <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   n_ack_a;
  int   n_ack_b;
  int   n_both;
  int   n_we;

  logic        pre_we;
  logic [10:0] pre_addr;
  logic [7:0]  pre_data;
  logic [7:0]  ram [0:2047];

  ram_arbiter_if #(.ADDR_WIDTH(11), .DATA_WIDTH(8)) bus ();

  ram_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port RAM model with a bench-only preload port.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.mem_write_enable) ram[bus.mem_address] <= bus.mem_data_in;
    bus.mem_data_out <= ram[bus.mem_address];
  end

  initial begin
    n_ack_a = 0; n_ack_b = 0; n_both = 0; n_we = 0;
  end
  always @(negedge clk) begin
    if (bus.ack_a) n_ack_a <= n_ack_a + 1;
    if (bus.ack_b) n_ack_b <= n_ack_b + 1;
    if (bus.ack_a && bus.ack_b) n_both <= n_both + 1;
    if (bus.mem_write_enable) n_we <= n_we + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [10:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ack_a"}, {31'd0, bus.ack_a}, 32'd0);
    check({tag, "_ack_b"}, {31'd0, bus.ack_b}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, bus.mem_write_enable}, 32'd0);
    check({tag, "_mem_addr"}, {21'd0, bus.mem_address}, 32'd0);
    check({tag, "_mem_din"}, {24'd0, bus.mem_data_in}, 32'd0);
    check({tag, "_rdata_a"}, {24'd0, bus.rdata_a}, 32'd0);
    check({tag, "_rdata_b"}, {24'd0, bus.rdata_b}, 32'd0);
  endtask

  // One complete transaction; lat = edges from the sampling edge to the edge
  // that raised ack (-1 on timeout). Req drops while ack is seen high.
  task automatic do_access(input string tag, input bit who_b, input logic we,
                           input logic [10:0] addr, input logic [7:0] wd,
                           output int lat, output logic [7:0] rd);
    int k;
    @(negedge clk);
    if (who_b) begin
      bus.req_b = 1'b1; bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wd;
    end else begin
      bus.req_a = 1'b1; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wd;
    end
    k   = cyc + 1;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (who_b ? bus.ack_b : bus.ack_a) begin
        lat = cyc - k;
        break;
      end
    end
    rd = who_b ? bus.rdata_b : bus.rdata_a;
    if (who_b) bus.req_b = 1'b0; else bus.req_a = 1'b0;
    @(negedge clk);
    check({tag, "_ack_one_cycle"}, {31'd0, (who_b ? bus.ack_b : bus.ack_a)}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [7:0]  rd;
    int          s_a, s_b, s_we, k, n;
    int          who [0:7];
    int          when [0:7];

    n_cmp = 0; n_err = 0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.req_a = 0; bus.req_b = 0; bus.we_a = 0; bus.we_b = 0;
    bus.addr_a = '0; bus.addr_b = '0; bus.wdata_a = '0; bus.wdata_b = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;

    // Single read by A
    preload(11'h123, 8'h5A);
    s_b = n_ack_b;
    do_access("rd_a", 1'b0, 1'b0, 11'h123, 8'h00, lat, rd);
    check("rd_a_latency", lat, 32'd2);
    check("rd_a_data", {24'd0, rd}, 32'h5A);
    check("rd_a_no_ack_b", n_ack_b - s_b, 32'd0);

    // B writes then reads back at the top address
    s_we = n_we;
    do_access("wr_b", 1'b1, 1'b1, 11'h7FF, 8'hC3, lat, rd);
    check("wr_b_latency", lat, 32'd2);
    check("wr_b_we_cycles", n_we - s_we, 32'd1);
    check("wr_b_rdata_kept", {24'd0, bus.rdata_b}, 32'h00);
    check("wr_b_ram", {24'd0, ram[11'h7FF]}, 32'hC3);
    do_access("rd_b", 1'b1, 1'b0, 11'h7FF, 8'h00, lat, rd);
    check("rd_b_data", {24'd0, rd}, 32'hC3);

    // Priority memory: A alone, then a tie goes to B
    do_access("pm_a", 1'b0, 1'b0, 11'h123, 8'h00, lat, rd);
    @(negedge clk);
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 11'h123;
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 11'h7FF;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ack_a || bus.ack_b) begin lat = i; break; end
    end
    check("pm_first_b", {30'd0, bus.ack_a, bus.ack_b}, 32'b01);
    bus.req_b = 1'b0;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ack_a) begin lat = i; break; end
    end
    check("pm_then_a", {31'd0, bus.ack_a}, 32'd1);
    bus.req_a = 1'b0;
    repeat (2) @(negedge clk);

    // Tie arbitration from reset with both requests held continuously
    pulse_reset();
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    k = cyc + 1;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (n < 8 && bus.ack_a) begin who[n] = 0; when[n] = cyc - k; n++; end
      if (n < 8 && bus.ack_b) begin who[n] = 1; when[n] = cyc - k; n++; end
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    check("tie_count", n, 32'd4);
    if (n >= 4) begin
      check("tie_order", {28'd0, who[0][0], who[1][0], who[2][0], who[3][0]}, 32'b0101);
      check("tie_t0", when[0], 32'd2);
      check("tie_t1", when[1], 32'd6);
      check("tie_t2", when[2], 32'd10);
      check("tie_t3", when[3], 32'd14);
    end
    check("never_both_acks", n_both, 32'd0);
    repeat (3) @(negedge clk);
    check("tie_idle", {31'd0, bus.busy}, 32'd0);

    // Reset during the ACCESS cycle of a write
    preload(11'h010, 8'h11);
    s_a = n_ack_a;
    @(negedge clk);
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 11'h010; bus.wdata_a = 8'h99;
    @(posedge clk);
    #2;
    check("rw_we_before", {31'd0, bus.mem_write_enable}, 32'd1);
    reset = 1'b0;
    #1;
    check("rw_we_async", {31'd0, bus.mem_write_enable}, 32'd0);
    bus.req_a = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rw");
    check("rw_ram_kept", {24'd0, ram[11'h010]}, 32'h11);
    check("rw_no_ack", n_ack_a - s_a, 32'd0);
    reset = 1'b1;

    // Abandoned sub-cycle req_b pulse while A is served
    preload(11'h055, 8'h44);
    s_b = n_ack_b; s_we = n_we;
    @(negedge clk);
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 11'h123;
    @(posedge clk);
    #2;
    bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 11'h055; bus.wdata_b = 8'hEE;
    #5;
    bus.req_b = 1'b0;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ack_a) begin lat = i; break; end
    end
    check("ab_a_served", {31'd0, bus.ack_a}, 32'd1);
    check("ab_a_data", {24'd0, bus.rdata_a}, 32'h5A);
    bus.req_a = 1'b0;
    repeat (8) @(negedge clk);
    check("ab_no_ack_b", n_ack_b - s_b, 32'd0);
    check("ab_no_write", n_we - s_we, 32'd0);
    check("ab_ram_kept", {24'd0, ram[11'h055]}, 32'h44);
    check("ab_never_both", n_both, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
